// File: rtl/clock_pkg.sv
// Shared definitions for the HH:MM:SS clock: mode encoding, BCD field limits
// and the BCD increment used by the time-set editor.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL   = 2'b00,
        MODE_SET_SEC  = 2'b01,
        MODE_SET_MIN  = 2'b10,
        MODE_SET_HOUR = 2'b11
    } mode_e;

    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HOUR_MAX = 8'h23;

    // Anything that is not a valid BCD value below the limit restarts at 00.
    function automatic logic [7:0] bcd_inc_wrap(input logic [7:0] val, input logic [7:0] lim);
        logic [7:0] res;
        if ((val[7:4] > 4'd9) || (val[3:0] > 4'd9) || (val >= lim)) begin
            res = 8'h00;
        end else if (val[3:0] == 4'd9) begin
            res = {val[7:4] + 4'd1, 4'd0};
        end else begin
            res = {val[7:4], val[3:0] + 4'd1};
        end
        return res;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle pulse on each released->pressed transition.
module key_debounce
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic i_clk,
    input  logic i_srst,
    input  logic i_key_n,
    output logic o_level,
    output logic o_press
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]       sync_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sample;

    assign sample = ~sync_q[1];

    // The counter only runs while the synchronized sample disagrees with the level.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = cnt_q;
        if (sample == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sample;
            press_d = sample;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            sync_q  <= 2'b11;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], i_key_n};
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_level = level_q;
    assign o_press = press_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set controller: mode FSM, per-field edit register with BCD increment,
// INC auto-repeat, registered load strobes, divider gating and blink phase.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int REPEAT_CYCLES   = 25_000_000,
    parameter int BLINK_CYCLES    = 12_500_000
) (
    input  logic       i_clk,
    input  logic       i_srst,
    input  logic       i_key_mode_n,
    input  logic       i_key_inc_n,
    input  logic [7:0] i_cur_sec,
    input  logic [7:0] i_cur_min,
    input  logic [7:0] i_cur_hour,
    output logic [1:0] o_mode,
    output logic       o_run_en,
    output logic       o_div_clr,
    output logic       o_load_sec,
    output logic       o_load_min,
    output logic       o_load_hour,
    output logic [7:0] o_load_data,
    output logic [7:0] o_edit_val,
    output logic       o_blink
);
    localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam int BLK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic mode_level_unused, mode_press, inc_level, inc_press;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .i_clk   (i_clk),
        .i_srst  (i_srst),
        .i_key_n (i_key_mode_n),
        .o_level (mode_level_unused),
        .o_press (mode_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
        .i_clk   (i_clk),
        .i_srst  (i_srst),
        .i_key_n (i_key_inc_n),
        .o_level (inc_level),
        .o_press (inc_press)
    );

    mode_e            state_q, state_d;
    logic [7:0]       edit_q, edit_d;
    logic [7:0]       load_data_q, load_data_d;
    logic             load_sec_q, load_sec_d;
    logic             load_min_q, load_min_d;
    logic             load_hour_q, load_hour_d;
    logic             div_clr_q, div_clr_d;
    logic             run_en_q, run_en_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_q, rep_d;
    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_q, blink_d;
    logic             in_set, inc_evt;

    assign in_set  = (state_q != MODE_NORMAL);
    // MODE wins over a coincident INC event.
    assign inc_evt = (inc_press | rep_q) & ~mode_press;

    always_comb begin
        state_d     = state_q;
        edit_d      = edit_q;
        load_data_d = load_data_q;
        load_sec_d  = 1'b0;
        load_min_d  = 1'b0;
        load_hour_d = 1'b0;
        div_clr_d   = 1'b0;
        case (state_q)
            MODE_NORMAL: begin
                if (mode_press) begin
                    state_d = MODE_SET_SEC;
                    edit_d  = i_cur_sec;
                end
            end
            MODE_SET_SEC: begin
                if (mode_press) begin
                    state_d     = MODE_SET_MIN;
                    load_sec_d  = 1'b1;
                    div_clr_d   = 1'b1;
                    load_data_d = edit_q;
                    edit_d      = i_cur_min;
                end else if (inc_evt) begin
                    edit_d = bcd_inc_wrap(edit_q, SEC_MAX);
                end
            end
            MODE_SET_MIN: begin
                if (mode_press) begin
                    state_d     = MODE_SET_HOUR;
                    load_min_d  = 1'b1;
                    load_data_d = edit_q;
                    edit_d      = i_cur_hour;
                end else if (inc_evt) begin
                    edit_d = bcd_inc_wrap(edit_q, MIN_MAX);
                end
            end
            MODE_SET_HOUR: begin
                if (mode_press) begin
                    state_d     = MODE_NORMAL;
                    load_hour_d = 1'b1;
                    load_data_d = edit_q;
                    edit_d      = 8'h00;
                end else if (inc_evt) begin
                    edit_d = bcd_inc_wrap(edit_q, HOUR_MAX);
                end
            end
            default: state_d = MODE_NORMAL;
        endcase
    end

    always_comb begin
        rep_cnt_d = '0;
        rep_d     = 1'b0;
        if (inc_level && in_set) begin
            if (rep_cnt_q == REP_W'(REPEAT_CYCLES - 1)) begin
                rep_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
        end

        // The divider stays stopped through the cycle the hour strobe is out.
        run_en_d = (state_d == MODE_NORMAL) && !load_hour_d;

        blink_cnt_d = '0;
        blink_d     = 1'b0;
        if ((state_d == state_q) && in_set) begin
            blink_d = blink_q;
            if (blink_cnt_q == BLK_W'(BLINK_CYCLES - 1)) begin
                blink_d = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLK_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state_q     <= MODE_NORMAL;
            edit_q      <= 8'h00;
            load_data_q <= 8'h00;
            load_sec_q  <= 1'b0;
            load_min_q  <= 1'b0;
            load_hour_q <= 1'b0;
            div_clr_q   <= 1'b0;
            run_en_q    <= 1'b1;
            rep_cnt_q   <= '0;
            rep_q       <= 1'b0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            edit_q      <= edit_d;
            load_data_q <= load_data_d;
            load_sec_q  <= load_sec_d;
            load_min_q  <= load_min_d;
            load_hour_q <= load_hour_d;
            div_clr_q   <= div_clr_d;
            run_en_q    <= run_en_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_q       <= rep_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign o_mode      = state_q;
    assign o_run_en    = run_en_q;
    assign o_div_clr   = div_clr_q;
    assign o_load_sec  = load_sec_q;
    assign o_load_min  = load_min_q;
    assign o_load_hour = load_hour_q;
    assign o_load_data = load_data_q;
    assign o_edit_val  = in_set ? edit_q : 8'h00;
    assign o_blink     = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed and randomized bench for clock_set_ctrl against a decimal-arithmetic
// model of the time-set behaviour.
module tb_clock_set_ctrl;
    localparam int DEB = 4;
    localparam int REP = 20;
    localparam int BLK = 8;

    logic       clk = 1'b0;
    logic       srst;
    logic       mode_n, inc_n;
    logic [7:0] cur_sec, cur_min, cur_hour;
    logic [1:0] o_mode;
    logic       o_run_en, o_div_clr, o_load_sec, o_load_min, o_load_hour, o_blink;
    logic [7:0] o_load_data, o_edit_val;

    always #5 clk = ~clk;

    clock_set_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_CYCLES  (REP),
        .BLINK_CYCLES   (BLK)
    ) dut (
        .i_clk        (clk),
        .i_srst       (srst),
        .i_key_mode_n (mode_n),
        .i_key_inc_n  (inc_n),
        .i_cur_sec    (cur_sec),
        .i_cur_min    (cur_min),
        .i_cur_hour   (cur_hour),
        .o_mode       (o_mode),
        .o_run_en     (o_run_en),
        .o_div_clr    (o_div_clr),
        .o_load_sec   (o_load_sec),
        .o_load_min   (o_load_min),
        .o_load_hour  (o_load_hour),
        .o_load_data  (o_load_data),
        .o_edit_val   (o_edit_val),
        .o_blink      (o_blink)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Strobe monitor
    int         cyc = 0;
    int         n_sec = 0, n_min = 0, n_hour = 0, n_clr = 0;
    int         clr_bad = 0, wide = 0, runen_bad = 0;
    int         change_cyc = 0;
    logic [7:0] last_data = 8'h00;
    logic       prev_strobe = 1'b0, prev_hour = 1'b0;
    logic [1:0] prev_mode = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_load_sec)  begin n_sec++;  last_data = o_load_data; end
        if (o_load_min)  begin n_min++;  last_data = o_load_data; end
        if (o_load_hour) begin n_hour++; last_data = o_load_data; end
        if (o_div_clr) n_clr++;
        if (o_div_clr !== o_load_sec) clr_bad++;
        if (prev_strobe && (o_load_sec || o_load_min || o_load_hour)) wide++;
        if (o_load_hour && o_run_en) runen_bad++;
        if (prev_hour && !o_run_en) runen_bad++;
        if (o_mode !== prev_mode) change_cyc = cyc;
        prev_mode   = o_mode;
        prev_strobe = o_load_sec | o_load_min | o_load_hour;
        prev_hour   = o_load_hour;
    end

    // Reference model: mode as 0..3, edit as BCD byte, arithmetic in decimal
    int         m_mode = 0;
    logic [7:0] m_edit = 8'h00;

    function automatic int dec_of(input logic [7:0] b);
        if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return -1;
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] bcd_of(input int d);
        logic [7:0] r;
        r[7:4] = 4'(d / 10);
        r[3:0] = 4'(d % 10);
        return r;
    endfunction

    function automatic int lim_of(input int mode);
        return (mode == 3) ? 23 : 59;
    endfunction

    function automatic logic [7:0] model_inc(input logic [7:0] e, input int lim);
        int d;
        d = dec_of(e);
        if (d < 0 || d > lim) return 8'h00;
        return bcd_of((d + 1) % (lim + 1));
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_total++;
        assert (obs === req) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, req);
        end
    endtask

    task automatic check_blink(input string tag);
        int k;
        k = cyc - change_cyc;
        check(tag, 32'(o_blink), (m_mode == 0) ? 32'd0 : 32'((k / BLK) % 2));
    endtask

    task automatic press(input bit m, input bit i, input int hold);
        if (m) mode_n = 1'b0;
        if (i) inc_n = 1'b0;
        tick(hold);
        mode_n = 1'b1;
        inc_n  = 1'b1;
        tick(12);
    endtask

    task automatic do_mode(input bit with_inc, input string tag);
        int         s0, s1, s2, d0, exp_strobe;
        logic [7:0] exp_data;
        s0 = n_sec; s1 = n_min; s2 = n_hour; d0 = n_clr;
        exp_data   = m_edit;
        exp_strobe = 0;
        press(1'b1, with_inc, 10);
        case (m_mode)
            0: begin m_mode = 1; m_edit = cur_sec; end
            1: begin exp_strobe = 'h100; m_mode = 2; m_edit = cur_min; end
            2: begin exp_strobe = 'h010; m_mode = 3; m_edit = cur_hour; end
            default: begin exp_strobe = 'h001; m_mode = 0; end
        endcase
        check($sformatf("%s.strobes", tag),
              32'(((n_sec - s0) << 8) | ((n_min - s1) << 4) | (n_hour - s2)), 32'(exp_strobe));
        check($sformatf("%s.div_clr", tag), 32'(n_clr - d0), (exp_strobe == 'h100) ? 32'd1 : 32'd0);
        if (exp_strobe != 0) check($sformatf("%s.load_data", tag), 32'(last_data), 32'(exp_data));
        check($sformatf("%s.mode", tag), 32'(o_mode), 32'(m_mode));
        check($sformatf("%s.run_en", tag), 32'(o_run_en), (m_mode == 0) ? 32'd1 : 32'd0);
        check($sformatf("%s.edit_val", tag), 32'(o_edit_val), (m_mode == 0) ? 32'd0 : 32'(m_edit));
        check_blink($sformatf("%s.blink", tag));
    endtask

    task automatic do_inc(input int hold, input string tag);
        press(1'b0, 1'b1, hold);
        if (m_mode != 0) repeat (1 + hold / REP) m_edit = model_inc(m_edit, lim_of(m_mode));
        check($sformatf("%s.edit_val", tag), 32'(o_edit_val), (m_mode == 0) ? 32'd0 : 32'(m_edit));
        check($sformatf("%s.mode", tag), 32'(o_mode), 32'(m_mode));
        check_blink($sformatf("%s.blink", tag));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, s1, s2;
        srst = 1'b1; mode_n = 1'b1; inc_n = 1'b1;
        cur_sec = 8'h56; cur_min = 8'h34; cur_hour = 8'h12;
        tick(3);
        srst = 1'b0;
        tick(1);
        check("rst.mode", 32'(o_mode), 32'd0);
        check("rst.run_en", 32'(o_run_en), 32'd1);
        check("rst.blink", 32'(o_blink), 32'd0);
        check("rst.edit_val", 32'(o_edit_val), 32'd0);
        check("rst.load_data", 32'(o_load_data), 32'd0);
        check("rst.strobes", 32'({o_load_sec, o_load_min, o_load_hour, o_div_clr}), 32'd0);

        do_inc(10, "inc_in_normal");

        // Bounce rejection, then a clean press
        repeat (5) begin
            mode_n = 1'b0; tick(3);
            mode_n = 1'b1; tick(5);
        end
        check("bounce.mode", 32'(o_mode), 32'd0);
        mode_n = 1'b0; tick(10);
        check("held.mode", 32'(o_mode), 32'd1);
        check("held.run_en", 32'(o_run_en), 32'd0);
        mode_n = 1'b1; tick(12);
        m_mode = 1; m_edit = cur_sec;
        check("held.edit_val", 32'(o_edit_val), 32'h56);

        // Full set cycle from 12:34:56
        for (int i = 0; i < 5; i++) do_inc(10, $sformatf("sec_inc%0d", i));
        check("sec_wrap", 32'(o_edit_val), 32'h01);
        do_mode(1'b0, "load_sec");
        check("load_sec.value", 32'(last_data), 32'h01);
        do_mode(1'b0, "load_min");
        do_mode(1'b0, "load_hour");

        // Hour wrap and out-of-range capture
        cur_hour = 8'h22;
        repeat (3) do_mode(1'b0, "to_hour");
        do_inc(10, "hour_23");
        check("hour_23.value", 32'(o_edit_val), 32'h23);
        do_inc(10, "hour_00");
        check("hour_00.value", 32'(o_edit_val), 32'h00);
        do_mode(1'b0, "hour_exit");
        cur_hour = 8'h24;
        repeat (3) do_mode(1'b0, "to_hour24");
        do_inc(10, "hour24_inc");
        check("hour24.value", 32'(o_edit_val), 32'h00);
        do_mode(1'b0, "hour24_exit");

        // Auto-repeat in SET_MIN
        cur_min = 8'h08;
        repeat (2) do_mode(1'b0, "to_min");
        do_inc(71, "repeat");
        check("repeat.value", 32'(o_edit_val), 32'h12);
        tick(30);
        check("repeat.released", 32'(o_edit_val), 32'h12);
        repeat (2) do_mode(1'b0, "repeat_exit");

        // MODE and INC together: MODE wins
        cur_sec = 8'h17;
        do_mode(1'b0, "simul_enter");
        do_inc(10, "simul_inc");
        do_mode(1'b1, "simul");
        check("simul.data", 32'(last_data), 32'h18);
        repeat (2) do_mode(1'b0, "simul_exit");

        // Randomized set cycles
        for (int r = 0; r < 4; r++) begin
            cur_sec  = (r == 3) ? 8'h5A : bcd_of($urandom_range(59, 0));
            cur_min  = (r == 3) ? 8'h60 : bcd_of($urandom_range(59, 0));
            cur_hour = bcd_of($urandom_range(23, 0));
            for (int f = 0; f < 3; f++) begin
                do_mode(1'b0, $sformatf("rnd%0d_mode%0d", r, f));
                repeat ($urandom_range(3, 0)) do_inc(10, $sformatf("rnd%0d_inc%0d", r, f));
            end
            do_mode(1'b0, $sformatf("rnd%0d_exit", r));
        end

        // Reset mid-edit
        cur_min = 8'h41;
        repeat (2) do_mode(1'b0, "rst_enter");
        do_inc(10, "rst_inc");
        s0 = n_sec; s1 = n_min; s2 = n_hour;
        srst = 1'b1; tick(1);
        srst = 1'b0;
        m_mode = 0; m_edit = 8'h00;
        check("midrst.mode", 32'(o_mode), 32'd0);
        check("midrst.run_en", 32'(o_run_en), 32'd1);
        check("midrst.blink", 32'(o_blink), 32'd0);
        check("midrst.edit_val", 32'(o_edit_val), 32'd0);
        tick(5);
        check("midrst.no_load", 32'((n_sec - s0) + (n_min - s1) + (n_hour - s2)), 32'd0);

        check("mon.div_clr_align", 32'(clr_bad), 32'd0);
        check("mon.strobe_width", 32'(wide), 32'd0);
        check("mon.run_en_timing", 32'(runen_bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
